// File: rtl/stream_packer.sv
// stream_packer
//   Output-side packer of the Sobel pipeline. Packs four 8-bit filtered pixels
//   into each 32-bit beat, little-endian: the first pixel of a beat lands in
//   [7:0]. Beats are buffered in a small FIFO and driven out as an AXI-Stream
//   master towards the S2MM DMA channel. m_axis_tlast marks the final beat of
//   each frame.
//
// Parameters
//   FRAME_PIXELS  pixels per frame, multiple of 4
//   FIFO_DEPTH    beat FIFO depth, power of 2, at least 2
//   SKID          free entries held back for upstream latency, < FIFO_DEPTH
//
// Ports
//   Clk                  clock
//   Rst                  synchronous, active-high reset
//   pixel_data_valid_in  filtered pixel present (always accepted)
//   pixel_data_in        filtered pixel
//   ready_out            advisory backpressure to upstream (dma_ready_in)
//   m_axis_tdata         packed beat
//   m_axis_tvalid        beat valid
//   m_axis_tready        DMA accepts beat
//   m_axis_tlast         last beat of frame
//   overflow_out         sticky flag, set on the first dropped beat
//
// Build option
//   STREAM_PACKER_OVF_EN  when defined, overflow_out latches the first dropped
//                         beat until Rst. When undefined the flag logic is
//                         removed and overflow_out is tied 0. Beats that find
//                         the FIFO full are dropped in both builds.

module stream_packer #(
  parameter int FRAME_PIXELS = 262144,
  parameter int FIFO_DEPTH   = 16,
  parameter int SKID         = 4
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        pixel_data_valid_in,
  input  logic [7:0]  pixel_data_in,
  output logic        ready_out,
  output logic [31:0] m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        m_axis_tlast,
  output logic        overflow_out
);

  localparam int PIX_W = (FRAME_PIXELS > 1) ? $clog2(FRAME_PIXELS) : 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  localparam logic [PIX_W-1:0] LAST_PIX = PIX_W'(FRAME_PIXELS - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] RDY_CNT  = CNT_W'(FIFO_DEPTH - SKID);

  typedef enum logic {ST_EMPTY, ST_VALID} out_state_e;

  out_state_e       r_state;
  logic [1:0]       r_lane;
  logic [PIX_W-1:0] r_pix_cnt;
  logic [23:0]      r_word;      // lanes 0..2 of the beat under construction
  logic [32:0]      r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;     // every buffered beat, including the one presented
  logic [31:0]      r_tdata;
  logic             r_tlast;
  logic             r_ready;

  logic             w_beat;
  logic             w_pop;
  logic             w_push;
  logic [32:0]      w_push_entry;
  logic [PTR_W-1:0] w_rd_ptr_nxt;
  logic [CNT_W-1:0] w_remain;
  logic [CNT_W-1:0] w_count_nxt;
  logic [32:0]      w_head_nxt;

  // NOTE: every signal is assigned on every path through this block, so no latches are inferred.
  always_comb begin
    w_beat       = pixel_data_valid_in && (r_lane == 2'd3);
    w_pop        = (r_state == ST_VALID) && m_axis_tready;
    // A full FIFO still takes a beat when the head leaves in the same cycle.
    w_push       = w_beat && ((r_count < FULL_CNT) || w_pop);
    w_push_entry = {(r_pix_cnt == LAST_PIX), pixel_data_in, r_word};
    w_rd_ptr_nxt = r_rd_ptr + PTR_W'(w_pop);
    w_remain     = r_count - CNT_W'(w_pop);
    w_count_nxt  = w_remain + CNT_W'(w_push);
    // Next head is the incoming beat when nothing else remains, otherwise an
    // entry that is already stored (never the slot being written this cycle).
    w_head_nxt   = (w_remain == '0) ? w_push_entry : r_mem[w_rd_ptr_nxt];
  end

  // NOTE: sequential state uses non-blocking assignments; reset is synchronous, so Rst is only looked at on the clock edge.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_state   <= ST_EMPTY;
      r_lane    <= '0;
      r_pix_cnt <= '0;
      r_word    <= '0;
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_tdata   <= '0;
      r_tlast   <= 1'b0;
      r_ready   <= 1'b1;
    end else begin
      // Counters advance on every accepted pixel, dropped beat or not, so
      // frame alignment survives an overflow.
      if (pixel_data_valid_in) begin
        r_lane    <= r_lane + 2'd1;
        r_pix_cnt <= (r_pix_cnt == LAST_PIX) ? '0 : r_pix_cnt + PIX_W'(1);
        case (r_lane)
          2'd0:    r_word[7:0]   <= pixel_data_in;
          2'd1:    r_word[15:8]  <= pixel_data_in;
          2'd2:    r_word[23:16] <= pixel_data_in;
          default: ;  // lane 3 goes straight into the pushed entry
        endcase
      end

      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      r_rd_ptr <= w_rd_ptr_nxt;
      r_count  <= w_count_nxt;
      r_ready  <= (r_count < RDY_CNT);

      // Output FSM: the presented beat is a registered copy of the FIFO head,
      // so it holds still whenever no pop occurs.
      if (w_count_nxt == '0) begin
        r_state <= ST_EMPTY;
      end else begin
        r_state <= ST_VALID;
        r_tdata <= w_head_nxt[31:0];
        r_tlast <= w_head_nxt[32];
      end
    end
  end

  // NOTE: the storage array has no reset; occupancy lives in r_count and the pointers, so stale entries are never presented.
  always_ff @(posedge Clk) begin
    if (!Rst && w_push) begin
      r_mem[r_wr_ptr] <= w_push_entry;
    end
  end

`ifdef STREAM_PACKER_OVF_EN
  logic w_drop;
  logic r_ovf;

  assign w_drop = w_beat && !w_push;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_ovf <= 1'b0;
    end else if (w_drop) begin
      r_ovf <= 1'b1;
    end
  end

  assign overflow_out = r_ovf;
`else
  assign overflow_out = 1'b0;
`endif

  assign ready_out     = r_ready;
  assign m_axis_tdata  = r_tdata;
  assign m_axis_tvalid = (r_state == ST_VALID);
  assign m_axis_tlast  = r_tlast;

endmodule
